hd_program_loader: RTL and testbench



---
 rtl/hd_loader_pkg.sv | 20 ++
 rtl/hd_loader_addr_gen.sv | 66 ++++++
 rtl/hd_program_loader.sv | 128 ++++++++++++
 tb/tb_hd_program_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hd_loader_pkg.sv
// Shared definitions for the HD program loader: state encoding, latency bounds, default RAM depth.
package hd_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam int HD_LAT_MIN     = 1;
    localparam int HD_LAT_MAX     = 4;
    localparam int INST_DEPTH_DEF = 256;
    // Wait counter only ever holds latency-1.
    localparam int WAIT_CNT_W     = $clog2(HD_LAT_MAX);

endpackage

// File: rtl/hd_loader_addr_gen.sv
// Latched transfer descriptor, word counter, HD/instruction address adders and end/range compares.
module hd_loader_addr_gen
    import hd_loader_pkg::*;
#(
    parameter int INST_DEPTH = INST_DEPTH_DEF,
    parameter int LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [31:0]      hd_base_i,
    input  logic [31:0]      inst_base_i,
    input  logic [LEN_W-1:0] length_i,
    output logic [31:0]      hd_addr_o,
    output logic [31:0]      inst_addr_o,
    output logic [LEN_W-1:0] word_count_o,
    output logic             last_word_o,
    output logic             range_err_o,
    output logic             len_zero_o
);

    logic [31:0]      hd_base_q, hd_base_d;
    logic [31:0]      inst_base_q, inst_base_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wc_q, wc_d;

    always_comb begin
        hd_base_d   = hd_base_q;
        inst_base_d = inst_base_q;
        len_d       = len_q;
        wc_d        = wc_q;
        if (load_i) begin
            hd_base_d   = hd_base_i;
            inst_base_d = inst_base_i;
            len_d       = length_i;
            wc_d        = '0;
        end else if (inc_i) begin
            wc_d = wc_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hd_base_q   <= '0;
            inst_base_q <= '0;
            len_q       <= '0;
            wc_q        <= '0;
        end else begin
            hd_base_q   <= hd_base_d;
            inst_base_q <= inst_base_d;
            len_q       <= len_d;
            wc_q        <= wc_d;
        end
    end

    assign hd_addr_o    = hd_base_q + {{(32-LEN_W){1'b0}}, wc_q};
    assign inst_addr_o  = inst_base_q + {{(32-LEN_W){1'b0}}, wc_q};
    assign word_count_o = wc_q;
    // Only evaluated while wc_q < len_q, so the increment cannot wrap.
    assign last_word_o  = (wc_q + LEN_W'(1)) == len_q;
    // 33-bit sum so a base near 2^32 cannot wrap past the depth check.
    assign range_err_o  = ({1'b0, inst_base_q} + {{(33-LEN_W){1'b0}}, len_q}) > 33'(INST_DEPTH);
    assign len_zero_o   = len_q == '0;

endmodule

// File: rtl/hd_program_loader.sv
// Copies Length words from HD into instruction RAM while stalling the PC.
// Optional running checksum of written words: define HD_LOADER_CHECKSUM_EN.
module hd_program_loader
    import hd_loader_pkg::*;
#(
    parameter int HD_LATENCY = 1,
    parameter int INST_DEPTH = INST_DEPTH_DEF,
    parameter int LEN_W      = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Abort,
    input  logic [31:0]      HdBase,
    input  logic [31:0]      InstBase,
    input  logic [LEN_W-1:0] Length,
    input  logic [31:0]      HdData,
    output logic [31:0]      HdAddr,
    output logic             HdRead,
    output logic [31:0]      InstAddr,
    output logic [31:0]      InstData,
    output logic             InstWrite,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic [LEN_W-1:0] WordCount,
    output logic [31:0]      Checksum
);

    localparam int LAT = (HD_LATENCY < HD_LAT_MIN) ? HD_LAT_MIN :
                         (HD_LATENCY > HD_LAT_MAX) ? HD_LAT_MAX : HD_LATENCY;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(LAT - 1);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [31:0]             data_q, data_d;
    logic                    accept, write_cyc;
    logic                    last_word, range_err, len_zero;

    assign accept    = (state_q == ST_IDLE) && Start && !Abort;
    assign write_cyc = (state_q == ST_WRITE);

    hd_loader_addr_gen #(
        .INST_DEPTH (INST_DEPTH),
        .LEN_W      (LEN_W)
    ) u_addr_gen (
        .clk_i        (CLK),
        .rst_i        (Reset),
        .load_i       (accept),
        .inc_i        (write_cyc),
        .hd_base_i    (HdBase),
        .inst_base_i  (InstBase),
        .length_i     (Length),
        .hd_addr_o    (HdAddr),
        .inst_addr_o  (InstAddr),
        .word_count_o (WordCount),
        .last_word_o  (last_word),
        .range_err_o  (range_err),
        .len_zero_o   (len_zero)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_CHECK;
            ST_CHECK: state_d = range_err ? ST_ERR : (len_zero ? ST_DONE : ST_REQ);
            ST_REQ: begin
                state_d = ST_WAIT;
                wcnt_d  = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    data_d  = HdData;
                    state_d = ST_WRITE;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            ST_WRITE: state_d = last_word ? ST_DONE : ST_REQ;
            default:  state_d = ST_IDLE;
        endcase
        // Abort only redirects the next state; this cycle's strobes still go out.
        if (Abort && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
        end
    end

    assign HdRead    = (state_q == ST_REQ);
    assign InstWrite = write_cyc;
    assign InstData  = data_q;
    assign Stall     = (state_q != ST_IDLE);
    assign Busy      = Stall;
    assign Done      = (state_q == ST_DONE);
    assign Error     = (state_q == ST_ERR);

`ifdef HD_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (accept)         csum_d = '0;
        else if (write_cyc) csum_d = csum_q + data_q;
    end

    always_ff @(posedge CLK) begin
        if (Reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign Checksum = csum_q;
`else
    assign Checksum = '0;
`endif

endmodule

// File: tb/tb_hd_program_loader.sv
// Randomized scoreboard bench for hd_program_loader with an HD latency model and timeline reference.
module tb_hd_program_loader;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;
    localparam int LW    = 16;

    logic          CLK = 1'b0, Reset = 1'b1, Start = 1'b0, Abort = 1'b0;
    logic [31:0]   HdBase = '0, InstBase = '0, HdData;
    logic [LW-1:0] Length = '0;
    logic [31:0]   HdAddr, InstAddr, InstData, Checksum;
    logic          HdRead, InstWrite, Stall, Busy, Done, Error;
    logic [LW-1:0] WordCount;

    always #5 CLK = ~CLK;

    hd_program_loader #(.HD_LATENCY(LAT), .INST_DEPTH(DEPTH), .LEN_W(LW)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Abort(Abort),
        .HdBase(HdBase), .InstBase(InstBase), .Length(Length), .HdData(HdData),
        .HdAddr(HdAddr), .HdRead(HdRead), .InstAddr(InstAddr), .InstData(InstData),
        .InstWrite(InstWrite), .Stall(Stall), .Busy(Busy), .Done(Done), .Error(Error),
        .WordCount(WordCount), .Checksum(Checksum)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // HD model: word at address a is 0xA0 + a, valid LAT cycles after the read strobe.
    logic [31:0] pa [1:LAT];
    logic        pv [1:LAT];
    initial for (int i = 1; i <= LAT; i++) begin pa[i] = '0; pv[i] = 1'b0; end
    always @(posedge CLK) begin
        pa[1] <= HdAddr;
        pv[1] <= HdRead;
        for (int i = 2; i <= LAT; i++) begin pa[i] <= pa[i-1]; pv[i] <= pv[i-1]; end
    end
    assign HdData = pv[LAT] ? 32'hA0 + pa[LAT] : 32'hDEAD_BEEF;

    typedef struct { int c; logic [31:0] a; logic [31:0] d; } acc_t;
    typedef struct { int c; bit err; } ev_t;
    acc_t rq[$], wq[$];
    ev_t  eq[$];
    int   busy_lo = 1, busy_hi = 0;
    bit   mon_en = 1'b0;
    int   tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected reads/writes/pulses whenever the DUT presents one.
    always @(negedge CLK) if (mon_en) begin
        acc_t x;
        ev_t  e;
        chk("stall", Stall, (cyc >= busy_lo && cyc <= busy_hi));
        chk("busy", Busy, Stall);
        if (HdRead) begin
            if (rq.size() == 0) chk("unexpected_hdread", 1, 0);
            else begin
                x = rq.pop_front();
                chk("rd_cycle", cyc, x.c);
                chk("rd_addr", HdAddr, x.a);
            end
        end
        if (InstWrite) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                x = wq.pop_front();
                chk("wr_cycle", cyc, x.c);
                chk("wr_addr", InstAddr, x.a);
                chk("wr_data", InstData, x.d);
            end
        end
        if (Done || Error) begin
            if (eq.size() == 0) chk("unexpected_pulse", 1, 0);
            else begin
                e = eq.pop_front();
                chk("ev_cycle", cyc, e.c);
                chk("ev_error", Error, e.err);
                chk("ev_done", Done, !e.err);
            end
        end
    end

    // One transfer; abort_rel >= 1 asserts Abort in cycle t0+abort_rel.
    task automatic run_xfer(input logic [31:0] hd, input logic [31:0] ib, input int len, input int abort_rel);
        int t0, end_rel, cut, nw;
        bit err;
        logic [31:0] sum, exp_cs;
        @(negedge CLK);
        t0 = cyc;
        Start = 1'b1; HdBase = hd; InstBase = ib; Length = LW'(len);
        err = ({1'b0, ib} + 33'(len)) > 33'(DEPTH);
        end_rel = err ? 2 : 2 + len * (LAT + 2);
        cut = (abort_rel >= 1 && abort_rel < end_rel) ? abort_rel : end_rel;
        nw = 0; sum = '0;
        if (!err) for (int k = 0; k < len; k++) begin
            int rc, wc;
            rc = t0 + 2 + k * (LAT + 2);
            wc = t0 + 3 + LAT + k * (LAT + 2);
            if (rc <= t0 + cut) rq.push_back('{rc, hd + k, 0});
            if (wc <= t0 + cut) begin
                wq.push_back('{wc, ib + k, 32'hA0 + hd + k});
                nw++;
                sum += 32'hA0 + hd + k;
            end
        end
        if (end_rel <= cut) eq.push_back('{t0 + end_rel, err});
        busy_lo = t0 + 1; busy_hi = t0 + cut;
        @(negedge CLK);
        while (cyc <= t0 + cut) begin
            Abort = (cyc == t0 + abort_rel);
            // A second request while busy must be ignored.
            Start = (cyc == t0 + 2) && (cut >= 2);
            HdBase = $urandom; InstBase = $urandom_range(0, 40); Length = LW'($urandom_range(1, 9));
            @(negedge CLK);
        end
        Abort = 1'b0; Start = 1'b0;
`ifdef HD_LOADER_CHECKSUM_EN
        exp_cs = sum;
`else
        exp_cs = '0;
`endif
        chk("idle_after", Stall, 0);
        chk("wordcount", WordCount, nw);
        chk("checksum", Checksum, exp_cs);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_hdaddr"}, HdAddr, 0);
        chk({tag, "_hdread"}, HdRead, 0);
        chk({tag, "_instaddr"}, InstAddr, 0);
        chk({tag, "_instdata"}, InstData, 0);
        chk({tag, "_instwrite"}, InstWrite, 0);
        chk({tag, "_stall"}, Stall, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_error"}, Error, 0);
        chk({tag, "_wordcount"}, WordCount, 0);
        chk({tag, "_checksum"}, Checksum, 0);
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        check_all_zero("reset");
        mon_en = 1'b1;

        run_xfer(32'h40, 32'h10, 3, -1);                  // basic, checksum 0x2A3
        run_xfer(32'h1000, 32'd250, 7, -1);               // range error
        run_xfer(32'h2000, 32'd5, 0, -1);                 // zero length
        run_xfer(32'h3000, 32'd248, 8, -1);               // exactly fills the RAM
        run_xfer(32'h3000, 32'd249, 8, -1);               // one past the end
        run_xfer(32'h4000, 32'hFFFF_FFFF, 2, -1);         // would wrap at 32 bits
        run_xfer(32'h100, 32'h20, 5, 3 + LAT + (LAT + 2)); // abort in second WRITE

        // Start and Abort together in IDLE
        @(negedge CLK);
        Start = 1'b1; Abort = 1'b1;
        @(negedge CLK);
        Start = 1'b0; Abort = 1'b0;
        chk("start_abort_idle", Stall, 0);
        @(negedge CLK);
        chk("start_abort_idle2", Stall, 0);

        // Reset during WAIT
        @(negedge CLK);
        t0 = cyc;
        Start = 1'b1; HdBase = 32'h500; InstBase = 32'h30; Length = LW'(4);
        rq.push_back('{t0 + 2, 32'h500, 0});
        busy_lo = t0 + 1; busy_hi = t0 + 3;
        @(negedge CLK);
        Start = 1'b0;
        while (cyc < t0 + 3) @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        check_all_zero("midreset");
        chk("midreset_rq_drained", rq.size(), 0);
        wq.delete(); eq.delete();
        run_xfer(32'h600, 32'h40, 2, -1);

        for (int n = 0; n < 30; n++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
            run_xfer($urandom, $urandom_range(0, 260), $urandom_range(0, 8), ab);
        end

        repeat (2) @(negedge CLK);
        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        chk("eq_empty", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
